// File: rtl/efuse_trim_loader.sv
// Boot-time eFuse trim loader: settles, reads one 32-bit eFuse word, checks it, retries, and falls back to DEFAULT_TRIM.
// Optional feature macro: EFUSE_PARITY_CHECK_EN (even parity over the captured word); undefined = every capture passes.
module efuse_trim_loader #(
  parameter int          SETTLE_CYCLES  = 256,
  parameter int          TIMEOUT_CYCLES = 32768,
  parameter int          MAX_RETRY      = 3,
  parameter logic [31:0] DEFAULT_TRIM   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  output logic        read_start,
  input  logic        read_ack,
  input  logic [31:0] efuse_dout,
  input  logic        dout_valid,
  output logic [31:0] trim_word,
  output logic        trim_valid,
  output logic        load_busy,
  output logic        load_err,
  output logic [1:0]  retry_cnt
);

  localparam int             CW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]     RETRY_LIMIT  = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_SETTLE, S_REQ, S_WAIT_ACK, S_WAIT_DATA, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_dout_valid_d;
  logic [31:0]   r_cap;

  logic          r_read_start, w_read_start_next;
  logic [31:0]   r_trim_word,  w_trim_word_next;
  logic          r_trim_valid, w_trim_valid_next;
  logic          r_load_busy,  w_load_busy_next;
  logic          r_load_err,   w_load_err_next;
  logic [1:0]    r_retry_cnt,  w_retry_cnt_next;

  logic          w_dv_rise;
  logic          w_timeout;
  logic          w_check_pass;
  logic          w_attempt_fail;
  logic          w_retry_ok;

  assign w_dv_rise  = dout_valid & ~r_dout_valid_d;
  assign w_timeout  = (r_cnt == TIMEOUT_LAST);
  assign w_retry_ok = (r_retry_cnt < RETRY_LIMIT);

`ifdef EFUSE_PARITY_CHECK_EN
  assign w_check_pass = ~(^r_cap);
`else
  assign w_check_pass = 1'b1;
`endif

  // An ack or a data edge arriving in the timeout cycle still wins over the timeout.
  assign w_attempt_fail = ((r_state == S_WAIT_ACK)  && !read_ack  && w_timeout) ||
                          ((r_state == S_WAIT_DATA) && !w_dv_rise && w_timeout) ||
                          ((r_state == S_CHECK)     && !w_check_pass);

  // State register, shared counter, capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_SETTLE;
      r_cnt          <= '0;
      r_dout_valid_d <= 1'b0;
      r_cap          <= '0;
      r_read_start   <= 1'b0;
      r_trim_word    <= DEFAULT_TRIM;
      r_trim_valid   <= 1'b0;
      r_load_busy    <= 1'b1;
      r_load_err     <= 1'b0;
      r_retry_cnt    <= 2'd0;
    end else begin
      r_state        <= w_state_next;
      r_dout_valid_d <= dout_valid;
      if (w_state_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_WAIT_ACK || r_state == S_WAIT_DATA)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_WAIT_DATA && w_dv_rise)
        r_cap <= efuse_dout;
      r_read_start   <= w_read_start_next;
      r_trim_word    <= w_trim_word_next;
      r_trim_valid   <= w_trim_valid_next;
      r_load_busy    <= w_load_busy_next;
      r_load_err     <= w_load_err_next;
      r_retry_cnt    <= w_retry_cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SETTLE:    if (r_cnt == SETTLE_LAST) w_state_next = S_REQ;
      S_REQ:       w_state_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (read_ack)  w_state_next = S_WAIT_DATA;
      S_WAIT_DATA: if (w_dv_rise) w_state_next = S_CHECK;
      S_CHECK:     if (w_check_pass) w_state_next = S_DONE;
      S_DONE,
      S_FAIL:      if (reload) w_state_next = S_REQ;
      default:     w_state_next = S_SETTLE;
    endcase
    if (w_attempt_fail)
      w_state_next = w_retry_ok ? S_REQ : S_FAIL;
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    w_read_start_next = r_read_start;
    w_trim_word_next  = r_trim_word;
    w_trim_valid_next = r_trim_valid;
    w_load_busy_next  = r_load_busy;
    w_load_err_next   = r_load_err;
    w_retry_cnt_next  = r_retry_cnt;
    case (r_state)
      S_REQ:      w_read_start_next = 1'b1;
      S_WAIT_ACK: if (read_ack) w_read_start_next = 1'b0;
      S_CHECK: begin
        if (w_check_pass) begin
          w_trim_word_next  = r_cap;
          w_trim_valid_next = 1'b1;
          w_load_busy_next  = 1'b0;
        end
      end
      S_DONE, S_FAIL: begin
        // The previous trim stays on the analog side until a new word checks good.
        if (reload) begin
          w_load_busy_next = 1'b1;
          w_load_err_next  = 1'b0;
          w_retry_cnt_next = 2'd0;
        end
      end
      default: ;
    endcase
    if (w_attempt_fail) begin
      w_read_start_next = 1'b0;
      if (w_retry_ok) begin
        w_retry_cnt_next = r_retry_cnt + 2'd1;
      end else begin
        w_trim_word_next  = DEFAULT_TRIM;
        w_trim_valid_next = 1'b0;
        w_load_err_next   = 1'b1;
        w_load_busy_next  = 1'b0;
      end
    end
  end

  assign read_start = r_read_start;
  assign trim_word  = r_trim_word;
  assign trim_valid = r_trim_valid;
  assign load_busy  = r_load_busy;
  assign load_err   = r_load_err;
  assign retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_efuse_trim_loader.sv
// Directed bench for efuse_trim_loader with a small eFuse driver model (ack 3 cycles after request, data 20 cycles later).
module tb_efuse_trim_loader;

  localparam int SETTLE = 16;
  localparam int TMO    = 64;
  localparam int MR     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        reload;
  logic        read_start;
  logic        read_ack;
  logic [31:0] efuse_dout;
  logic        dout_valid;
  logic [31:0] trim_word;
  logic        trim_valid;
  logic        load_busy;
  logic        load_err;
  logic [1:0]  retry_cnt;

  efuse_trim_loader #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MR),
    .DEFAULT_TRIM  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reload    (reload),
    .read_start(read_start),
    .read_ack  (read_ack),
    .efuse_dout(efuse_dout),
    .dout_valid(dout_valid),
    .trim_word (trim_word),
    .trim_valid(trim_valid),
    .load_busy (load_busy),
    .load_err  (load_err),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] bfm_q[$];
  int          bfm_skip_total = 0;
  bit          bfm_ack_en     = 1'b1;
  int          pulses;
  int          tw_changes;
  bit          tv_dropped;
  logic [31:0] tw_first_pulse;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Driver model: skips requests when told to, otherwise acks and returns the next queued word.
  initial begin : bfm
    int skipped;
    skipped    = 0;
    read_ack   = 1'b0;
    dout_valid = 1'b0;
    efuse_dout = 32'h0;
    forever begin
      @(negedge clk);
      if (read_start) begin
        if (!bfm_ack_en || skipped < bfm_skip_total) begin
          if (bfm_ack_en) skipped++;
          for (int k = 0; k < 200 && read_start; k++) @(negedge clk);
        end else begin
          repeat (2) @(negedge clk);
          read_ack = 1'b1;
          @(negedge clk);
          read_ack = 1'b0;
          if (bfm_q.size() > 0) efuse_dout = bfm_q.pop_front();
          repeat (19) @(negedge clk);
          dout_valid = 1'b1;
          repeat (2) @(negedge clk);
          dout_valid = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int max);
    logic        prev_rs;
    logic [31:0] prev_tw;
    bit          done;
    prev_rs        = read_start;
    prev_tw        = trim_word;
    done           = 1'b0;
    pulses         = 0;
    tw_changes     = 0;
    tv_dropped     = 1'b0;
    tw_first_pulse = trim_word;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (read_start && !prev_rs) begin
        pulses++;
        if (pulses == 1) tw_first_pulse = trim_word;
      end
      if (trim_word !== prev_tw) tw_changes++;
      if (!trim_valid) tv_dropped = 1'b1;
      prev_rs = read_start;
      prev_tw = trim_word;
      if (!load_busy) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (read_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    reload = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_read_start", {31'd0, read_start}, 32'd0);
    check_eq("rst_trim_word",  trim_word,             32'h0000_0000);
    check_eq("rst_trim_valid", {31'd0, trim_valid}, 32'd0);
    check_eq("rst_load_busy",  {31'd0, load_busy},  32'd1);
    check_eq("rst_load_err",   {31'd0, load_err},   32'd0);
    check_eq("rst_retry_cnt",  {30'd0, retry_cnt},  32'd0);

    // 1: power-up load
    bfm_q.push_back(32'h8000_0001);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    check_eq("t1_rs_c16", {31'd0, read_start}, 32'd0);
    @(negedge clk);
    check_eq("t1_rs_c17", {31'd0, read_start}, 32'd1);
    wait_idle("t1", 1000);
    check_eq("t1_trim_word",  trim_word,             32'h8000_0001);
    check_eq("t1_trim_valid", {31'd0, trim_valid}, 32'd1);
    check_eq("t1_load_busy",  {31'd0, load_busy},  32'd0);
    check_eq("t1_retry_cnt",  {30'd0, retry_cnt},  32'd0);
    check_eq("t1_load_err",   {31'd0, load_err},   32'd0);

    // 4: reload from DONE, old trim held until the new word checks
    bfm_q.push_back(32'hC000_0000);
    pulse_reload();
    check_eq("t4_busy", {31'd0, load_busy}, 32'd1);
    wait_idle("t4", 1000);
    check_eq("t4_tw_at_req",   tw_first_pulse,        32'h8000_0001);
    check_eq("t4_tw_changes",  tw_changes,            32'd1);
    check_eq("t4_tv_dropped",  {31'd0, tv_dropped}, 32'd0);
    check_eq("t4_trim_word",   trim_word,             32'hC000_0000);
    check_eq("t4_pulses",      pulses,                32'd1);

`ifdef EFUSE_PARITY_CHECK_EN
    // 2: three parity failures then a good word
    bfm_q.push_back(32'h0000_0001);
    bfm_q.push_back(32'h0000_0001);
    bfm_q.push_back(32'h0000_0001);
    bfm_q.push_back(32'h0000_0003);
    pulse_reload();
    wait_idle("t2", 1000);
    check_eq("t2_pulses",     pulses,                4);
    check_eq("t2_retry_cnt",  {30'd0, retry_cnt},  32'd3);
    check_eq("t2_trim_word",  trim_word,             32'h0000_0003);
    check_eq("t2_trim_valid", {31'd0, trim_valid}, 32'd1);
    check_eq("t2_load_err",   {31'd0, load_err},   32'd0);
`endif

    // one ack timeout, then success on the retry
    bfm_skip_total = bfm_skip_total + 1;
    bfm_q.push_back(32'h0000_00F0);
    pulse_reload();
    wait_idle("tr", 1000);
    check_eq("tr_pulses",    pulses,               32'd2);
    check_eq("tr_retry_cnt", {30'd0, retry_cnt}, 32'd1);
    check_eq("tr_trim_word", trim_word,            32'h0000_00F0);
    check_eq("tr_load_err",  {31'd0, load_err},  32'd0);

    // 3: driver never acks -> final failure
    bfm_ack_en = 1'b0;
    pulse_reload();
    wait_idle("t3", 1000);
    check_eq("t3_pulses",     pulses,                32'd4);
    check_eq("t3_load_err",   {31'd0, load_err},   32'd1);
    check_eq("t3_trim_valid", {31'd0, trim_valid}, 32'd0);
    check_eq("t3_trim_word",  trim_word,             32'h0000_0000);
    check_eq("t3_read_start", {31'd0, read_start}, 32'd0);
    check_eq("t3_retry_cnt",  {30'd0, retry_cnt},  32'd3);

    // recovery by reload from FAIL
    bfm_ack_en = 1'b1;
    bfm_q.push_back(32'h0000_0303);
    pulse_reload();
    check_eq("rf_load_err_clr", {31'd0, load_err},  32'd0);
    check_eq("rf_retry_clr",    {30'd0, retry_cnt}, 32'd0);
    wait_idle("rf", 1000);
    check_eq("rf_trim_word",  trim_word,             32'h0000_0303);
    check_eq("rf_trim_valid", {31'd0, trim_valid}, 32'd1);

    // 5: reset during WAIT_DATA, stale data edge lands in SETTLE
    bfm_q.push_back(32'h5A5A_0000);
    bfm_q.push_back(32'h0000_A5A5);
    pulse_reload();
    wait_ack("t5");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_busy",  {31'd0, load_busy},  32'd1);
    check_eq("t5_rst_valid", {31'd0, trim_valid}, 32'd0);
    check_eq("t5_rst_trim",  trim_word,             32'h0000_0000);
    check_eq("t5_rst_rs",    {31'd0, read_start}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // 6: reload during SETTLE must not shorten it
    repeat (5) @(negedge clk);
    pulse_reload();
    repeat (10) @(negedge clk);
    check_eq("t5_rs_c16", {31'd0, read_start}, 32'd0);
    @(negedge clk);
    check_eq("t5_rs_c17", {31'd0, read_start}, 32'd1);
    check_eq("t5_valid_pre", {31'd0, trim_valid}, 32'd0);
    // 6: reload during WAIT_DATA is ignored
    wait_ack("t6");
    repeat (5) @(negedge clk);
    pulse_reload();
    wait_idle("t6", 1000);
    check_eq("t6_pulses",     pulses,                32'd0);
    check_eq("t6_trim_word",  trim_word,             32'h0000_A5A5);
    check_eq("t6_trim_valid", {31'd0, trim_valid}, 32'd1);
    check_eq("t6_retry_cnt",  {30'd0, retry_cnt},  32'd0);
    check_eq("t6_load_err",   {31'd0, load_err},   32'd0);
    repeat (5) @(negedge clk);
    check_eq("t6_rs_idle",    {31'd0, read_start}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
